// File: rtl/i2c_write_master_if.sv
// Pin and request bundle for the I2C write master.
// The master modport is the design's view; slave is the controlling/pad side.
interface i2c_write_master_if #(
    parameter int unsigned ADDR_W = 7
);
    logic              tick;
    logic              start;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        reg_addr;
    logic [7:0]        data;
    logic              sda_in;
    logic              scl;
    logic              sda_oe;
    logic              busy;
    logic              done;
    logic              ack_err;

    modport master (
        input  tick, start, addr, reg_addr, data, sda_in,
        output scl, sda_oe, busy, done, ack_err
    );

    modport slave (
        output tick, start, addr, reg_addr, data, sda_in,
        input  scl, sda_oe, busy, done, ack_err
    );
endinterface

// File: rtl/i2c_write_master.sv
// Single-transaction I2C write master: START, {addr,W}, reg byte, data byte, STOP.
// Bus phases advance on rising edges of the divider's tick square wave.
module i2c_write_master #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic                 clk_in,
    input  logic                 reset,
    i2c_write_master_if.master   bus
);
    localparam int unsigned SHIFT_W   = ADDR_W + 17;
    localparam logic [3:0]  ACK_BIT   = 4'd8;
    localparam logic [1:0]  LAST_BYTE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_STOP,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_tick_d;
    logic [1:0]         r_phase;
    logic [3:0]         r_bit;
    logic [1:0]         r_byte;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_scl;
    logic               r_sda_oe;
    logic               r_busy;
    logic               r_done;
    logic               r_ack_err;
    logic               w_phase_en;

    assign w_phase_en = bus.tick & ~r_tick_d;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_tick_d  <= 1'b0;
            r_phase   <= 2'd0;
            r_bit     <= 4'd0;
            r_byte    <= 2'd0;
            r_shift   <= '0;
            r_scl     <= 1'b1;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_tick_d <= bus.tick;
            r_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_scl    <= 1'b1;
                    r_sda_oe <= 1'b0;
                    if (bus.start) begin
                        r_shift   <= {bus.addr, 1'b0, bus.reg_addr, bus.data};
                        r_busy    <= 1'b1;
                        r_ack_err <= 1'b0;
                        r_phase   <= 2'd0;
                        r_state   <= S_START;
                    end
                end
                // SDA falls while SCL is high, then SCL drops
                S_START: begin
                    if (w_phase_en) begin
                        if (r_phase == 2'd0) begin
                            r_sda_oe <= 1'b1;
                            r_phase  <= 2'd1;
                        end else begin
                            r_scl   <= 1'b0;
                            r_phase <= 2'd0;
                            r_bit   <= 4'd0;
                            r_byte  <= 2'd0;
                            r_state <= S_BIT;
                        end
                    end
                end
                S_BIT: begin
                    if (w_phase_en) begin
                        r_phase <= r_phase + 2'd1;
                        case (r_phase)
                            2'd0: begin
                                r_scl    <= 1'b0;
                                r_sda_oe <= (r_bit == ACK_BIT) ? 1'b0 : ~r_shift[SHIFT_W-1];
                            end
                            2'd1: r_scl <= 1'b1;
                            2'd2: begin
                                r_scl <= 1'b1;
                                if ((r_bit == ACK_BIT) && bus.sda_in) begin
                                    r_ack_err <= 1'b1;
                                end
                            end
                            default: begin
                                r_scl <= 1'b0;
                                if (r_bit != ACK_BIT) begin
                                    r_bit   <= r_bit + 4'd1;
                                    r_shift <= {r_shift[SHIFT_W-2:0], 1'b0};
                                end else begin
                                    // ack_err can only be set by this byte's ACK slot
                                    r_bit <= 4'd0;
                                    if (r_ack_err || (r_byte == LAST_BYTE)) begin
                                        r_state <= S_STOP;
                                    end else begin
                                        r_byte <= r_byte + 2'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                S_STOP: begin
                    if (w_phase_en) begin
                        case (r_phase)
                            2'd0: begin
                                r_scl    <= 1'b0;
                                r_sda_oe <= 1'b1;
                                r_phase  <= 2'd1;
                            end
                            2'd1: begin
                                r_scl   <= 1'b1;
                                r_phase <= 2'd2;
                            end
                            default: begin
                                r_sda_oe <= 1'b0;
                                r_phase  <= 2'd0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.scl     = r_scl;
    assign bus.sda_oe  = r_sda_oe;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.ack_err = r_ack_err;
endmodule
